// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: shared definitions for the ram_dma block-copy engine.
// Holds the FSM state encoding and the default address/data widths.
package ram_dma_pkg;

   localparam int ADDR_BITS_DEF = 16;
   localparam int WIDTH_DEF     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_dma.sv
// ram_dma: single-channel byte block-copy engine driving a single-port RAM.
// A start pulse in IDLE latches src/dst/len and copies len bytes forward,
// one READ cycle plus one WRITE cycle per byte. Addresses wrap modulo
// 2**ADDR_BITS. The RAM returns data for the registered mem_addr on mem_do
// within the same cycle, so the byte is captured on the READ->WRITE edge.
// Optional feature macro: RAM_DMA_FILL_EN adds fill/fill_val, a write-only
// mode that stores fill_val at dst..dst+len-1, one byte per cycle.
module ram_dma
   import ram_dma_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int WIDTH     = WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] src,
   input  logic [ADDR_BITS-1:0] dst,
   input  logic [ADDR_BITS-1:0] len,
`ifdef RAM_DMA_FILL_EN
   input  logic                 fill,
   input  logic [WIDTH-1:0]     fill_val,
`endif
   output logic                 busy,
   output logic                 done,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [WIDTH-1:0]     mem_di,
   input  logic [WIDTH-1:0]     mem_do
);

   state_t               state, state_nxt;
   logic [ADDR_BITS-1:0] src_ptr, src_ptr_nxt;
   logic [ADDR_BITS-1:0] dst_ptr, dst_ptr_nxt;
   logic [ADDR_BITS-1:0] count, count_nxt;
   logic                 fill_mode, fill_mode_nxt;
   logic                 busy_nxt, done_nxt, mem_we_nxt;
   logic [ADDR_BITS-1:0] mem_addr_nxt;
   logic [WIDTH-1:0]     mem_di_nxt;

   // Fill-mode request and byte; tied off when the fill feature is absent.
   logic                 fill_sel;
   logic [WIDTH-1:0]     fill_byte;
`ifdef RAM_DMA_FILL_EN
   assign fill_sel  = fill;
   assign fill_byte = fill_val;
`else
   assign fill_sel  = 1'b0;
   assign fill_byte = '0;
`endif

   // State, pointers and all registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed for this edge, independent of statement order.
      if (rst) begin
         state     <= IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         count     <= '0;
         fill_mode <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_di    <= '0;
      end else begin
         state     <= state_nxt;
         src_ptr   <= src_ptr_nxt;
         dst_ptr   <= dst_ptr_nxt;
         count     <= count_nxt;
         fill_mode <= fill_mode_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_di    <= mem_di_nxt;
      end
   end

   // Next-state and next-output decode for the copy/fill sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_nxt     = state;
      src_ptr_nxt   = src_ptr;
      dst_ptr_nxt   = dst_ptr;
      count_nxt     = count;
      fill_mode_nxt = fill_mode;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      mem_we_nxt    = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_di_nxt    = mem_di;

      case (state)
         IDLE: begin
            if (start) begin
               src_ptr_nxt   = src;
               dst_ptr_nxt   = dst;
               count_nxt     = len;
               fill_mode_nxt = fill_sel;
               if (len == '0) begin
                  state_nxt = DONE;
               end else if (fill_sel) begin
                  // First fill byte goes out immediately; count tracks the
                  // writes still owed after this one.
                  state_nxt    = WRITE;
                  busy_nxt     = 1'b1;
                  mem_we_nxt   = 1'b1;
                  mem_addr_nxt = dst;
                  mem_di_nxt   = fill_byte;
                  count_nxt    = len - 1'b1;
               end else begin
                  state_nxt    = READ;
                  busy_nxt     = 1'b1;
                  mem_addr_nxt = src;
               end
            end
         end

         READ: begin
            state_nxt    = WRITE;
            busy_nxt     = 1'b1;
            mem_we_nxt   = 1'b1;
            mem_addr_nxt = dst_ptr;
            mem_di_nxt   = mem_do;
            src_ptr_nxt  = src_ptr + 1'b1;
            count_nxt    = count - 1'b1;
         end

         WRITE: begin
            if (count != '0) begin
               busy_nxt    = 1'b1;
               dst_ptr_nxt = dst_ptr + 1'b1;
               if (fill_mode) begin
                  // mem_di already holds the fill byte; just advance.
                  mem_we_nxt   = 1'b1;
                  mem_addr_nxt = dst_ptr + 1'b1;
                  count_nxt    = count - 1'b1;
               end else begin
                  state_nxt    = READ;
                  mem_addr_nxt = src_ptr;
               end
            end else begin
               state_nxt = DONE;
            end
         end

         DONE: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: self-checking bench for ram_dma.
// A bench-side RAM answers the DUT; a shadow array plus a per-cycle timeline
// derived from transfer length/mode give the expected bus activity.
// Builds with or without RAM_DMA_FILL_EN.
module tb_ram_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] src = '0, dst = '0, len = '0;
`ifdef RAM_DMA_FILL_EN
   logic        fill = 1'b0;
   logic [7:0]  fill_val = '0;
`endif
   logic        busy, done, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_di, mem_do;

   always #5 clk = ~clk;

   ram_dma dut (
      .clk(clk), .rst(rst), .start(start),
      .src(src), .dst(dst), .len(len),
`ifdef RAM_DMA_FILL_EN
      .fill(fill), .fill_val(fill_val),
`endif
      .busy(busy), .done(done), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
   );

   // Bench RAM: the DUT's registered mem_addr acts as the RAM address
   // register, so read data follows it within the cycle.
   logic [7:0]  ram [0:65535];
   logic        bd_we = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;
   always @(posedge clk) begin
      if (mem_we)     ram[mem_addr] <= mem_di;
      else if (bd_we) ram[bd_addr]  <= bd_data;
   end
   assign mem_do = ram[mem_addr];

   // Reference model state.
   logic [7:0]  shadow [0:65535];
   logic [7:0]  wdata [0:63];
   int          n_tests = 0, n_fail = 0;
   int          req_id = 0, ack_id = 0;
   logic [15:0] x_src = '0, x_dst = '0;
   int          x_len = 0;
   bit          x_fill = 1'b0;
   int          done_t = -1, busy_cnt = 0, we_cnt = 0;
   logic [15:0] rd_log [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   // Per-cycle comparison against the timeline implied by the active transfer.
   task automatic compare_loop();
      int t = 0;
      int cur = 0;
      int act;
      int k;
      logic [15:0] ea;
      forever begin
         @(negedge clk);
         if (rst) begin
            ack_id = req_id;
         end else if (ack_id == req_id) begin
            check("idle", {29'd0, busy, done, mem_we}, 32'd0);
         end else begin
            if (cur != req_id) begin
               cur = req_id; t = 0; busy_cnt = 0; we_cnt = 0; done_t = -1;
               rd_log.delete();
            end
            act = (x_len == 0) ? 0 : (x_fill ? x_len : 2 * x_len);
            if (busy)   busy_cnt++;
            if (mem_we) we_cnt++;
            if (t < act) begin
               check("busy", {30'd0, busy, done}, 32'd2);
               if (x_fill || (t % 2 == 1)) begin
                  k  = x_fill ? t : t / 2;
                  ea = x_dst + 16'(k);
                  check("wr_we", {31'd0, mem_we}, 32'd1);
                  check("wr_addr", {16'd0, mem_addr}, {16'd0, ea});
                  check("wr_data", {24'd0, mem_di}, {24'd0, wdata[k]});
               end else begin
                  k  = t / 2;
                  ea = x_src + 16'(k);
                  check("rd_we", {31'd0, mem_we}, 32'd0);
                  check("rd_addr", {16'd0, mem_addr}, {16'd0, ea});
                  rd_log.push_back(mem_addr);
               end
            end else if (t == act) begin
               check("done_state", {29'd0, busy, done, mem_we}, 32'd0);
            end else begin
               check("done_pulse", {29'd0, busy, done, mem_we}, 32'd2);
               done_t = t;
               ack_id = req_id;
            end
            t++;
         end
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      bd_addr = a; bd_data = d; bd_we = 1'b1;
      @(posedge clk); #1;
      bd_we = 1'b0;
      shadow[a] = d;
   endtask

   // Random contents around both regions so every compared byte is known.
   task automatic prep(input logic [15:0] s, input logic [15:0] d, input int n);
      for (int i = -2; i < n + 2; i++) poke(s + 16'(i), 8'($urandom));
      for (int i = -2; i < n + 2; i++) poke(d + 16'(i), 8'($urandom));
   endtask

   task automatic verify_window(input string name, input logic [15:0] base, input int n);
      int bad = 0;
      logic [15:0] a;
      for (int i = -2; i < n + 2; i++) begin
         a = base + 16'(i);
         if (ram[a] !== shadow[a]) bad++;
      end
      check(name, bad, 0);
   endtask

   // Model the transfer, launch it, and wait (bounded) for the compare
   // process to see the done pulse. abort_at>=0 resets after that many writes.
   task automatic go(input logic [15:0] s, input logic [15:0] d, input int n,
                     input bit f, input logic [7:0] v, input bit noise, input int abort_at);
      int act, e;
      logic [7:0] b;
      for (int k = 0; k < n; k++) begin
         b = f ? v : shadow[s + 16'(k)];
         if (abort_at < 0 || k < abort_at) shadow[d + 16'(k)] = b;
         if (k < 64) wdata[k] = b;
      end
      src = s; dst = d; len = 16'(n); start = 1'b1;
`ifdef RAM_DMA_FILL_EN
      fill = f; fill_val = v;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      x_src = s; x_dst = d; x_len = n; x_fill = f;
      req_id++;
      act = (n == 0) ? 0 : (f ? n : 2 * n);
      e = 0;
      while (ack_id != req_id) begin
         if (abort_at >= 0 && e == 2 * abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check("rst_we", {31'd0, mem_we}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            rst = 1'b0;
            break;
         end
         if (noise && e <= act) begin
            start = 1'($urandom_range(0, 1));
            src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
`ifdef RAM_DMA_FILL_EN
            fill = 1'($urandom_range(0, 1)); fill_val = 8'($urandom);
`endif
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         e++;
         if (e > act + 4) begin
            check("timeout", ack_id, req_id);
            finish_run();
         end
      end
      start = 1'b0;
      if (abort_at >= 0) begin
         repeat (6) begin
            @(posedge clk); #1;
            check("abort_no_done", {31'd0, done}, 32'd0);
         end
      end
      verify_window("ram_src", s, n);
      verify_window("ram_dst", d, n);
   endtask

   initial begin
      logic [15:0] s, d;
      int n;
      bit f;
      fork
         compare_loop();
      join_none

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", {29'd0, busy, done, mem_we}, 32'd0);
      check("reset_addr", {16'd0, mem_addr}, 32'd0);
      check("reset_di", {24'd0, mem_di}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic 4-byte copy.
      prep(16'h0010, 16'h0100, 4);
      poke(16'h0010, 8'h11); poke(16'h0011, 8'h22);
      poke(16'h0012, 8'h33); poke(16'h0013, 8'h44);
      go(16'h0010, 16'h0100, 4, 1'b0, 8'h00, 1'b0, -1);
      check("t1_b0", {24'd0, ram[16'h0100]}, 32'h11);
      check("t1_b1", {24'd0, ram[16'h0101]}, 32'h22);
      check("t1_b2", {24'd0, ram[16'h0102]}, 32'h33);
      check("t1_b3", {24'd0, ram[16'h0103]}, 32'h44);
      check("t1_done_edge", done_t, 9);
      check("t1_busy_cycles", busy_cnt, 8);

      // Zero-length request.
      prep(16'h0300, 16'h0400, 0);
      go(16'h0300, 16'h0400, 0, 1'b0, 8'h00, 1'b0, -1);
      check("t2_no_we", we_cnt, 0);
      check("t2_done_edge", done_t, 1);

      // Overlapping forward copy repeats the first byte.
      prep(16'h0020, 16'h0021, 3);
      poke(16'h0020, 8'hAA);
      go(16'h0020, 16'h0021, 3, 1'b0, 8'h00, 1'b0, -1);
      check("t3_b0", {24'd0, ram[16'h0021]}, 32'hAA);
      check("t3_b1", {24'd0, ram[16'h0022]}, 32'hAA);
      check("t3_b2", {24'd0, ram[16'h0023]}, 32'hAA);

      // Address wrap on the source side, overlapping the destination.
      prep(16'hFFFE, 16'h0000, 4);
      poke(16'hFFFE, 8'h12); poke(16'hFFFF, 8'h34);
      poke(16'h0000, 8'h56); poke(16'h0001, 8'h78);
      go(16'hFFFE, 16'h0000, 4, 1'b0, 8'h00, 1'b0, -1);
      check("t4_rd0", {16'd0, rd_log[0]}, 32'hFFFE);
      check("t4_rd1", {16'd0, rd_log[1]}, 32'hFFFF);
      check("t4_rd2", {16'd0, rd_log[2]}, 32'h0000);
      check("t4_rd3", {16'd0, rd_log[3]}, 32'h0001);
      check("t4_b0", {24'd0, ram[16'h0000]}, 32'h12);
      check("t4_b1", {24'd0, ram[16'h0001]}, 32'h34);
      check("t4_b2", {24'd0, ram[16'h0002]}, 32'h12);
      check("t4_b3", {24'd0, ram[16'h0003]}, 32'h34);

      // Reset after the second write of an 8-byte copy.
      prep(16'h0500, 16'h0600, 8);
      go(16'h0500, 16'h0600, 8, 1'b0, 8'h00, 1'b0, 2);
      check("t5_no_done", done_t, -1);

      // start pulses while busy must be ignored.
      prep(16'h0700, 16'h0800, 6);
      go(16'h0700, 16'h0800, 6, 1'b0, 8'h00, 1'b1, -1);
      check("t6_done_edge", done_t, 13);

`ifdef RAM_DMA_FILL_EN
      // Fill mode.
      prep(16'h0000, 16'h0200, 3);
      go(16'h0000, 16'h0200, 3, 1'b1, 8'h5A, 1'b0, -1);
      check("t7_b0", {24'd0, ram[16'h0200]}, 32'h5A);
      check("t7_b1", {24'd0, ram[16'h0201]}, 32'h5A);
      check("t7_b2", {24'd0, ram[16'h0202]}, 32'h5A);
      check("t7_done_edge", done_t, 4);
`endif

      // Randomized transfers.
      for (int it = 0; it < 25; it++) begin
         n = $urandom_range(0, 24);
         s = 16'($urandom);
         if ($urandom_range(0, 1) == 1) d = s + 16'($urandom_range(0, 6)) - 16'd3;
         else                           d = 16'($urandom);
         f = 1'b0;
`ifdef RAM_DMA_FILL_EN
         f = ($urandom_range(0, 3) == 0);
`endif
         prep(s, d, n);
         go(s, d, n, f, 8'($urandom), 1'($urandom_range(0, 1)), -1);
         @(posedge clk); #1;
      end

      finish_run();
   end

endmodule
